// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU results in a FIFO and streams them out
// as bytes, high byte first. Define ALU_SER_TAG_EN to prefix each result with {4'hA, op}.
module alu_result_serializer #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [15:0]   result,
    input  logic          result_enable,
    input  logic [3:0]    op,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    input  logic          byte_ready,
    output logic [AW:0]   fifo_count,
    output logic          busy,
    output logic          overflow,
    input  logic          clear_overflow
);

`ifdef ALU_SER_TAG_EN
    localparam int EW = 20;
`else
    localparam int EW = 16;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_HI   = 2'd2,
        S_LO   = 2'd3
    } state_t;

`ifdef ALU_SER_TAG_EN
    localparam state_t S_FIRST = S_TAG;
`else
    localparam state_t S_FIRST = S_HI;
`endif

    state_t state_q, state_d;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] hold_q, hold_d;
    logic [EW-1:0] wr_data;
    logic [EW-1:0] rd_data;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;

    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic       busy_q, busy_d;
    logic       overflow_q, overflow_d;

    logic full;
    logic empty;
    logic hs;
    logic pop;
    logic push_ok;
    logic drop;

`ifdef ALU_SER_TAG_EN
    assign wr_data = {op, result};
`else
    logic unused_op;
    assign unused_op = ^op;
    assign wr_data   = result;
`endif

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign hs      = byte_valid_q && byte_ready;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    // FIFO storage; contents need no reset since pointers gate every read
    always_ff @(posedge clock) begin
        if (reset_n && push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // State, pointers, holding register and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next state and pop decision; LO chains straight into the next entry
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_FIRST;
                end
            end
`ifdef ALU_SER_TAG_EN
            S_TAG: begin
                if (hs) state_d = S_HI;
            end
`endif
            S_HI: begin
                if (hs) state_d = S_LO;
            end
            S_LO: begin
                if (hs) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_FIRST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; a pop frees the slot a same-edge push needs when full
    always_comb begin
        push_ok  = result_enable && (!full || pop);
        drop     = result_enable && full && !pop;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        hold_d   = pop ? rd_data : hold_q;
    end

    // Output registers computed from the upcoming state and holding value
    always_comb begin
        byte_out_d   = 8'h00;
        byte_valid_d = 1'b0;
        case (state_d)
`ifdef ALU_SER_TAG_EN
            S_TAG: begin
                byte_out_d   = {4'hA, hold_d[19:16]};
                byte_valid_d = 1'b1;
            end
`endif
            S_HI: begin
                byte_out_d   = hold_d[15:8];
                byte_valid_d = 1'b1;
            end
            S_LO: begin
                byte_out_d   = hold_d[7:0];
                byte_valid_d = 1'b1;
            end
            default: begin
                byte_out_d   = 8'h00;
                byte_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE) || (count_d != '0);
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: directed checks of the ALU result byte serializer.
// Expectations follow ALU_SER_TAG_EN when the bench is built with it.
module tb_alu_result_serializer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] result;
    logic        result_enable;
    logic [3:0]  op;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        overflow;
    logic        clear_overflow;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ALU_SER_TAG_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    alu_result_serializer #(.DEPTH(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .result         (result),
        .result_enable  (result_enable),
        .op             (op),
        .byte_out       (byte_out),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .fifo_count     (fifo_count),
        .busy           (busy),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] first_byte(input logic [3:0] o,
                                              input logic [15:0] r);
`ifdef ALU_SER_TAG_EN
        return {4'hA, o};
`else
        return r[15:8];
`endif
    endfunction

    task automatic take(input string tag, input logic [7:0] b);
        chk({tag, "_valid"}, 32'(byte_valid), 32'd1);
        chk(tag, 32'(byte_out), 32'(b));
        step();
    endtask

    task automatic take_result(input string tag, input logic [3:0] o,
                               input logic [15:0] r);
`ifdef ALU_SER_TAG_EN
        take({tag, "_tag"}, {4'hA, o});
`endif
        take({tag, "_hi"}, r[15:8]);
        take({tag, "_lo"}, r[7:0]);
    endtask

    logic [7:0] eq[$];

    initial begin
        reset_n        = 1'b0;
        result         = 16'hFFFF;
        result_enable  = 1'b1;
        op             = 4'hF;
        byte_ready     = 1'b1;
        clear_overflow = 1'b0;

        // reset with a push held high
        step();
        step();
        chk("rst_byte_out", 32'(byte_out), 32'h0);
        chk("rst_valid", 32'(byte_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);

        // single push, two-edge latency
        reset_n = 1'b1;
        result  = 16'h1234;
        op      = 4'h5;
        step();
        result_enable = 1'b0;
        chk("single_count", 32'(fifo_count), 32'd1);
        chk("single_nvalid", 32'(byte_valid), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        step();
        take_result("single", 4'h5, 16'h1234);
        chk("single_idle", 32'(byte_valid), 32'd0);
        chk("single_nbusy", 32'(busy), 32'd0);

        // backpressure holds the first byte
        byte_ready    = 1'b0;
        result_enable = 1'b1;
        result        = 16'hBEEF;
        op            = 4'h3;
        step();
        result_enable = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(byte_valid), 32'd1);
            chk("bp_hold", 32'(byte_out), 32'(first_byte(4'h3, 16'hBEEF)));
            step();
        end
        byte_ready = 1'b1;
        #1;
        take_result("bp", 4'h3, 16'hBEEF);
        chk("bp_idle", 32'(byte_valid), 32'd0);

        // burst of four, no gaps
        eq.delete();
        for (int i = 1; i <= 4; i++) begin
`ifdef ALU_SER_TAG_EN
            eq.push_back({4'hA, 4'(i)});
`endif
            eq.push_back(8'h00);
            eq.push_back(8'(i));
        end
        for (int c = 0; c <= eq.size(); c++) begin
            result_enable = (c < 4);
            result        = 16'(c + 1);
            op            = 4'(c + 1);
            step();
            if (c >= 1) begin
                chk("burst_valid", 32'(byte_valid), 32'd1);
                chk("burst_byte", 32'(byte_out), 32'(eq[c-1]));
            end
        end
        result_enable = 1'b0;
        step();
        chk("burst_idle", 32'(byte_valid), 32'd0);
        chk("burst_novf", 32'(overflow), 32'd0);

        // overflow with the consumer stalled
        byte_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            result_enable = 1'b1;
            result        = 16'h1100 + 16'(i);
            op            = 4'(i);
            step();
        end
        result_enable = 1'b0;
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd1);
        chk("ovf_held", 32'(byte_out), 32'(first_byte(4'h0, 16'h1100)));

        clear_overflow = 1'b1;
        result_enable  = 1'b1;
        result         = 16'h2222;
        step();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_count2", 32'(fifo_count), 32'd4);
        result_enable = 1'b0;
        step();
        chk("ovf_clear", 32'(overflow), 32'd0);
        clear_overflow = 1'b0;

        // push accepted on a full FIFO when the same edge pops
        byte_ready = 1'b1;
        for (int i = 0; i < NB - 1; i++) step();
        chk("full_lo", 32'(byte_out), 32'h00);
        result_enable = 1'b1;
        result        = 16'h3333;
        step();
        byte_ready    = 1'b0;
        result_enable = 1'b0;
        chk("full_pp_count", 32'(fifo_count), 32'd4);
        chk("full_pp_novf", 32'(overflow), 32'd0);
        chk("full_pp_next", 32'(byte_out), 32'(first_byte(4'h1, 16'h1101)));

        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("rst2_valid", 32'(byte_valid), 32'd0);
        chk("rst2_count", 32'(fifo_count), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_byte", 32'(byte_out), 32'd0);

        // reset while in LO with two queued
        result_enable = 1'b1;
        result = 16'hA1B2; op = 4'h1; step();
        result = 16'hC3D4; op = 4'h2; step();
        result = 16'hE5F6; op = 4'h3; step();
        result_enable = 1'b0;
        byte_ready    = 1'b1;
        for (int i = 0; i < NB - 1; i++) step();
        byte_ready = 1'b0;
        chk("mid_lo", 32'(byte_out), 32'hB2);
        chk("mid_count", 32'(fifo_count), 32'd2);
        reset_n = 1'b0;
        step();
        reset_n    = 1'b1;
        byte_ready = 1'b1;
        chk("mid_rst_valid", 32'(byte_valid), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_quiet", 32'(byte_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Downstream stage of the ALU. Captures every 16-bit result the ALU presents with `result_enable`, buffers it in a small FIFO, and serializes each result onto an 8-bit byte stream with a valid/ready handshake, high byte first. This lets the ALU issue results back-to-back while a slow byte-wide consumer (UART/SPI bridge) drains them.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two, 2..16.
- `AW`, default `$clog2(DEPTH)`: FIFO pointer width.

Ports:
- `clock`: in, 1. Single clock; all logic is posedge.
- `reset_n`: in, 1. Reset is synchronous and active-low.
- `result`: in, 16. ALU `Result`.
- `result_enable`: in, 1. One push per cycle sampled high.
- `op`: in, 4. ALU `control` value that produced `result`. Captured alongside it.
- `byte_out`: out, 8. Current output byte.
- `byte_valid`: out, 1. `byte_out` is valid.
- `byte_ready`: in, 1. Consumer accepts the byte on any edge where `byte_valid && byte_ready`.
- `fifo_count`: out, AW+1. Number of entries buffered, excluding the entry being serialized.
- `busy`: out, 1. High when the FSM is not IDLE or `fifo_count != 0`.
- `overflow`: out, 1. Sticky. Set when a push is dropped.
- `clear_overflow`: in, 1. Synchronous clear of `overflow`.

## Operation
- FIFO entry is `{op[3:0], result[15:0]}`, 20 bits wide. It uses wr/rd pointers of AW+1 bits.
  - Full: `fifo_count == DEPTH`.
  - Empty: `fifo_count == 0`.
  - Pointers wrap modulo 2^(AW+1).
- Push: on an edge where `result_enable` = 1.
  - If not full, the entry is written.
  - If full and no pop happens on the same edge, the push is dropped and `overflow` is set.
  - If full and a pop happens on the same edge, the push is accepted and `fifo_count` is unchanged.
- Pop: performed by the FSM when loading its shift register.
- FSM states: IDLE, TAG (only with the macro), HI, LO.
  - **IDLE:** if the FIFO is not empty, pop into the holding register and go to the first byte state (TAG or HI). `byte_valid` = 0.
  - **TAG:** `byte_out = {4'hA, op}`, `byte_valid` = 1. On handshake, go to HI.
  - **HI:** `byte_out = result[15:8]`, `byte_valid` = 1. On handshake, go to LO.
  - **LO:** `byte_out = result[7:0]`, `byte_valid` = 1. On handshake:
    - If the FIFO is not empty, pop the next entry and go directly to the first byte state (no idle bubble).
    - Otherwise, go to IDLE.
- Handshake rules:
  - While `byte_valid` = 1 and `byte_ready` = 0, `byte_out` is held stable.
  - `byte_valid` never drops without a handshake, except on reset.
- `overflow`:
  - Set on a dropped push.
  - Cleared by `clear_overflow` = 1.
  - If a set and a clear occur on the same edge, set wins.
- Reset (`reset_n` = 0 at an edge):
  - FSM goes to IDLE. Pointers, `fifo_count`, and the holding register clear.
  - Outputs: `byte_out` = 0, `byte_valid` = 0, `busy` = 0, `overflow` = 0.
  - A reset mid-serialization discards the partial result and all buffered entries.
  - A push sampled on a reset edge is ignored.

## Timing
- All outputs are registered.
- Latency from an empty, idle block: `result_enable` is sampled at edge k, the FIFO is written at edge k, and the FSM pops at edge k+1. `byte_valid` = 1 with the HI (or TAG) byte after edge k+1.
- Throughput:
  - 2 bytes per result, or 3 with TAG.
  - With `byte_ready` held at 1, one byte per clock with no gaps between results.
- `fifo_count` updates on the same edge as the push/pop that changes it.
- Sustained ALU issue at 1 result/clock overflows once DEPTH is exceeded. Upstream must throttle via `fifo_count` or `busy`.

## Configuration
- `ALU_SER_TAG_EN` defined:
  - Each result is sent as 3 bytes: the tag `{4'hA, op}`, then HI, then LO.
  - The `op` field is stored in the FIFO.
- Undefined:
  - TAG state and `op` storage are compiled out, and FIFO entries are 16 bits.
  - Each result is sent as 2 bytes. The `op` port remains and is ignored.

## Test plan
- Reset check: assert `reset_n` = 0 for 2 clocks with `result_enable` = 1 → all outputs 0 and `fifo_count` = 0. Single push of 16'h1234 afterwards with `byte_ready` = 1 → bytes 8'h12 then 8'h34 on consecutive cycles, starting 2 edges after the push, then `byte_valid` = 0.
- Backpressure: push 16'hBEEF with `byte_ready` = 0 for 5 cycles → `byte_out` holds 8'hBE with `byte_valid` = 1 throughout. Release `byte_ready` → 8'hBE, then 8'hEF.
- Burst with full drain: 4 consecutive pushes 16'h0001..16'h0004 with `byte_ready` = 1 → 8 bytes 00 01 00 02 00 03 00 04 with no gaps, and `overflow` = 0.
- Overflow: `byte_ready` = 0 and 6 consecutive pushes (DEPTH = 4) → the first is held in the FSM, `fifo_count` = 4, one push is dropped, and `overflow` = 1. `clear_overflow` and a dropped push on the same edge → `overflow` stays 1.
- Reset mid-operation: drop `reset_n` while in state LO with 2 entries queued → the next cycle has `byte_valid` = 0, `fifo_count` = 0, and no further bytes.
- With `ALU_SER_TAG_EN`: push 16'h00FF with `op` = 4'h2 → bytes 8'hA2, 8'h00, 8'hFF.
